// File: rtl/pipes_pkg.sv
// Shared types for the pipeline hazard controller: fetch tracking states
// and the bundle of per-stage stall/flush controls.
package pipes_pkg;

  typedef enum logic [1:0] {
    F_IDLE    = 2'd0,
    F_WAIT    = 2'd1,
    F_DISCARD = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
    logic flush_w;
  } hazard_t;

  localparam hazard_t HAZ_NONE = '0;

endpackage

// File: rtl/load_use_detect.sv
// Flags a D-stage instruction that reads the register a load in E is about
// to write; x0 is never a real dependency.
module load_use_detect
  import pipes_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_is_load,
  output logic             lu
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_use_rs1 & (id_rs1 == ex_rd);
  assign rs2_hit = id_use_rs2 & (id_rs2 == ex_rd);
  assign lu      = ex_is_load & (ex_rd != '0) & (rs1_hit | rs2_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: prioritises dbus wait, E-stage redirects,
// load-use and ibus wait into stall/flush controls, and tracks wrong-path fetches.
module hazard_ctrl
  import pipes_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_req_valid,
  input  logic             i_data_ok,
  input  logic             d_req_valid,
  input  logic             d_data_ok,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_is_load,
  input  logic             ex_redirect,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_e,
  output logic             flush_w,
  output logic             redirect_ok,
  output logic             fetch_discard,
  output logic [CNT_W-1:0] stall_cycles
);

  fetch_state_t     state;
  fetch_state_t     state_next;
  hazard_t          hz;
  logic             dstall;
  logic             redir;
  logic             lu;
  logic             istall;
  logic             discard;
  logic [CNT_W-1:0] cnt;

  load_use_detect #(.REG_W(REG_W)) u_lu (
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .ex_rd      (ex_rd),
    .ex_is_load (ex_is_load),
    .lu         (lu)
  );

  // A redirect cannot be taken while the whole pipe is frozen on the dbus.
  assign dstall  = d_req_valid & ~d_data_ok;
  assign redir   = ex_redirect & ~dstall;
  assign istall  = (state == F_IDLE) ? (i_req_valid & ~i_data_ok) : ~i_data_ok;
  assign discard = (state == F_DISCARD) & i_data_ok;

  always_ff @(posedge clk) begin
    if (!reset) state <= F_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      F_IDLE: begin
        if (i_req_valid & ~i_data_ok) state_next = redir ? F_DISCARD : F_WAIT;
      end
      F_WAIT: begin
        if (i_data_ok)  state_next = F_IDLE;
        else if (redir) state_next = F_DISCARD;
      end
      F_DISCARD: begin
        if (i_data_ok) state_next = F_IDLE;
      end
      default: state_next = F_IDLE;
    endcase
  end

  // A discarded response also holds F so the redirect target is refetched.
  always_comb begin
    hz            = HAZ_NONE;
    redirect_ok   = 1'b0;
    fetch_discard = 1'b0;
    if (reset) begin
      if (dstall) begin
        hz.stall_f = 1'b1;
        hz.stall_d = 1'b1;
        hz.stall_e = 1'b1;
        hz.stall_m = 1'b1;
        hz.flush_w = 1'b1;
      end else if (redir) begin
        hz.flush_d  = 1'b1;
        hz.flush_e  = 1'b1;
        hz.stall_f  = istall;
        redirect_ok = 1'b1;
      end else if (lu) begin
        hz.stall_f = 1'b1;
        hz.stall_d = 1'b1;
        hz.flush_e = 1'b1;
      end else if (istall) begin
        hz.stall_f = 1'b1;
        hz.flush_d = 1'b1;
      end
      if (discard) hz.stall_f = 1'b1;
      fetch_discard = discard;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset)                         cnt <= '0;
    else if (hz.stall_f && cnt != '1)   cnt <= cnt + CNT_W'(1);
  end

  assign stall_f      = hz.stall_f;
  assign stall_d      = hz.stall_d;
  assign stall_e      = hz.stall_e;
  assign stall_m      = hz.stall_m;
  assign flush_d      = hz.flush_d;
  assign flush_e      = hz.flush_e;
  assign flush_w      = hz.flush_w;
  assign stall_cycles = cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios then random traffic,
// checked against a fetch-outstanding/wrong-path reference model.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_req_valid, i_data_ok, d_req_valid, d_data_ok;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_is_load, ex_redirect;

  logic        stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w;
  logic        redirect_ok, fetch_discard;
  logic [31:0] stall_cycles;

  logic        s_stall_f, s_stall_d, s_stall_e, s_stall_m, s_flush_d, s_flush_e, s_flush_w;
  logic        s_redirect_ok, s_fetch_discard;
  logic [3:0]  s_stall_cycles;

  int assert_count = 0;
  int fail_count   = 0;

  bit         outstanding;
  bit         doomed;
  longint     stall_total;
  logic [8:0] exp_ctrl;
  bit         exp_stall_f;
  bit         exp_redir;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_W(5), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .i_req_valid(i_req_valid), .i_data_ok(i_data_ok),
    .d_req_valid(d_req_valid), .d_data_ok(d_data_ok),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_redirect(ex_redirect),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
    .redirect_ok(redirect_ok), .fetch_discard(fetch_discard),
    .stall_cycles(stall_cycles)
  );

  hazard_ctrl #(.REG_W(5), .CNT_W(4)) dut_small (
    .clk(clk), .reset(reset),
    .i_req_valid(i_req_valid), .i_data_ok(i_data_ok),
    .d_req_valid(d_req_valid), .d_data_ok(d_data_ok),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_redirect(ex_redirect),
    .stall_f(s_stall_f), .stall_d(s_stall_d), .stall_e(s_stall_e), .stall_m(s_stall_m),
    .flush_d(s_flush_d), .flush_e(s_flush_e), .flush_w(s_flush_w),
    .redirect_ok(s_redirect_ok), .fetch_discard(s_fetch_discard),
    .stall_cycles(s_stall_cycles)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assert_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input bit rst_n, input bit req, input bit ok,
                                input bit dreq, input bit dok, input bit redirect);
    reset       = rst_n;
    i_req_valid = req;
    i_data_ok   = ok;
    d_req_valid = dreq;
    d_data_ok   = dok;
    ex_redirect = redirect;
  endtask

  task automatic set_decode(input bit is_load, input logic [4:0] rd,
                            input logic [4:0] rs1, input bit use1,
                            input logic [4:0] rs2, input bit use2);
    ex_is_load = is_load;
    ex_rd      = rd;
    id_rs1     = rs1;
    id_use_rs1 = use1;
    id_rs2     = rs2;
    id_use_rs2 = use2;
  endtask

  // Expected controls from the priority rules and the fetch bookkeeping.
  task automatic compute_expected();
    bit dst, lu_e, ist, disc;
    bit sf, sd, se, sm, fd, fe, fw, rok;
    dst  = d_req_valid && !d_data_ok;
    exp_redir = ex_redirect && !dst;
    lu_e = ex_is_load && (ex_rd != 0) &&
           ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    ist  = (outstanding || i_req_valid) && !i_data_ok;
    disc = outstanding && doomed && i_data_ok;
    {sf, sd, se, sm, fd, fe, fw, rok} = '0;
    if (dst)            begin sf = 1; sd = 1; se = 1; sm = 1; fw = 1; end
    else if (exp_redir) begin fd = 1; fe = 1; rok = 1; sf = ist; end
    else if (lu_e)      begin sf = 1; sd = 1; fe = 1; end
    else if (ist)       begin sf = 1; fd = 1; end
    sf = sf || disc;
    if (!reset) begin
      {sf, sd, se, sm, fd, fe, fw, rok} = '0;
      disc = 0;
    end
    exp_stall_f = sf;
    exp_ctrl    = {sf, sd, se, sm, fd, fe, fw, rok, disc};
  endtask

  task automatic check_output();
    longint cap;
    compute_expected();
    cap = (stall_total > 15) ? 15 : stall_total;
    check_eq("ctrl", {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
                      redirect_ok, fetch_discard}, exp_ctrl);
    check_eq("ctrl_w4", {s_stall_f, s_stall_d, s_stall_e, s_stall_m, s_flush_d, s_flush_e,
                         s_flush_w, s_redirect_ok, s_fetch_discard}, exp_ctrl);
    check_eq("stall_cycles", stall_cycles, stall_total);
    check_eq("stall_cycles_w4", s_stall_cycles, cap);
  endtask

  task automatic update_model();
    if (!reset) begin
      outstanding = 0;
      doomed      = 0;
      stall_total = 0;
    end else begin
      if (exp_stall_f) stall_total++;
      if (outstanding) begin
        if (i_data_ok) begin
          outstanding = 0;
          doomed      = 0;
        end else if (exp_redir) begin
          doomed = 1;
        end
      end else if (i_req_valid && !i_data_ok) begin
        outstanding = 1;
        doomed      = exp_redir;
      end
    end
  endtask

  task automatic sample();
    @(negedge clk);
    check_output();
  endtask

  task automatic advance();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  initial begin
    apply_stimulus(0, 0, 0, 0, 0, 0);
    set_decode(0, 0, 0, 0, 0, 0);
    outstanding = 0;
    doomed      = 0;
    stall_total = 0;
    exp_stall_f = 0;
    exp_redir   = 0;
    @(posedge clk);
    update_model();
    #1;
    sample();
    check_eq("reset_ctrl", {stall_f, flush_d, flush_e, redirect_ok, fetch_discard}, 5'b0);
    check_eq("reset_cnt", stall_cycles, 0);
    advance();

    $display("[TB] load-use");
    apply_stimulus(1, 0, 0, 0, 0, 0);
    set_decode(1, 5, 5, 1, 1, 0);
    sample();
    check_eq("lu_stall_d", stall_d, 1);
    check_eq("lu_flush_e", flush_e, 1);
    advance();
    set_decode(0, 5, 6, 1, 1, 0);
    step();
    set_decode(1, 0, 0, 1, 0, 0);
    sample();
    check_eq("lu_x0_stall_f", stall_f, 0);
    advance();
    set_decode(0, 0, 0, 0, 0, 0);

    $display("[TB] dbus wait with pending redirect");
    apply_stimulus(1, 0, 0, 1, 0, 1);
    repeat (3) begin
      sample();
      check_eq("dwait_stall_m", stall_m, 1);
      check_eq("dwait_redirect_ok", redirect_ok, 0);
      advance();
    end
    apply_stimulus(1, 0, 0, 1, 1, 1);
    sample();
    check_eq("dwait_done_redirect_ok", redirect_ok, 1);
    check_eq("dwait_done_stall_m", stall_m, 0);
    advance();

    $display("[TB] redirect during fetch");
    apply_stimulus(1, 1, 0, 0, 0, 0);
    step();
    apply_stimulus(1, 0, 0, 0, 0, 1);
    step();
    apply_stimulus(1, 0, 0, 0, 0, 0);
    sample();
    check_eq("wrongpath_wait_discard", fetch_discard, 0);
    advance();
    apply_stimulus(1, 0, 1, 0, 0, 0);
    sample();
    check_eq("wrongpath_discard", fetch_discard, 1);
    check_eq("wrongpath_stall_f", stall_f, 1);
    advance();
    sample();
    check_eq("after_discard_idle", {stall_f, fetch_discard}, 2'b00);
    advance();

    $display("[TB] load-use together with redirect");
    apply_stimulus(1, 0, 0, 0, 0, 1);
    set_decode(1, 7, 7, 1, 0, 0);
    sample();
    check_eq("lu_redir", {flush_d, flush_e, stall_d}, 3'b110);
    advance();
    set_decode(0, 0, 0, 0, 0, 0);

    $display("[TB] reset while discarding");
    apply_stimulus(1, 1, 0, 0, 0, 0);
    step();
    apply_stimulus(1, 0, 0, 0, 0, 1);
    step();
    apply_stimulus(0, 0, 0, 0, 0, 0);
    sample();
    check_eq("rst_discard_ctrl", {stall_f, stall_d, stall_e, stall_m, flush_d, flush_e,
                                  flush_w, redirect_ok, fetch_discard}, 9'b0);
    advance();
    apply_stimulus(1, 0, 1, 0, 0, 0);
    sample();
    check_eq("rst_late_ok_discard", fetch_discard, 0);
    advance();

    $display("[TB] stall counter saturation");
    apply_stimulus(0, 0, 0, 0, 0, 0);
    step();
    apply_stimulus(1, 1, 0, 0, 0, 0);
    repeat (20) step();
    sample();
    check_eq("sat_w4", s_stall_cycles, 15);
    check_eq("sat_w32", stall_cycles, 20);
    advance();
    apply_stimulus(1, 0, 1, 0, 0, 0);
    step();

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      apply_stimulus(($urandom % 40) != 0, $urandom % 2, ($urandom % 3) == 0,
                     ($urandom % 3) == 0, $urandom % 2, ($urandom % 5) == 0);
      set_decode($urandom % 2, 5'($urandom % 8), 5'($urandom % 8), $urandom % 2,
                 5'($urandom % 8), $urandom % 2);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline controller for the 5-stage RV64 core (F/D/E/M/W).
- Generates per-stage stall and flush signals from four sources: the load-use hazard, branch/jump redirects resolved in E, instruction-bus wait, and data-bus wait.
- Tracks the outstanding fetch with a small FSM, so that a fetch response belonging to a redirected-away path is discarded.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- REG_W, 5, register index width
- CNT_W, 32, stall counter width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- i_req_valid  in  1  fetch stage has an instruction request on ibus this cycle
- i_data_ok  in  1  ibus response returned this cycle
- d_req_valid  in  1  M stage holds a load/store (memRw != 0)
- d_data_ok  in  1  dbus response returned this cycle
- id_rs1  in  REG_W  D-stage source register 1
- id_rs2  in  REG_W  D-stage source register 2
- id_use_rs1  in  1  D instruction reads rs1
- id_use_rs2  in  1  D instruction reads rs2
- ex_rd  in  REG_W  E-stage destination register
- ex_is_load  in  1  E instruction is a load (wbSelect == 2'b01, regWrite = 1)
- ex_redirect  in  1  E resolved a taken branch, JAL or JALR
- stall_f, stall_d, stall_e, stall_m  out  1 each  hold the pipeline register of that stage
- flush_d, flush_e, flush_w  out  1 each  insert a bubble into that stage next cycle
- redirect_ok  out  1  PC may take the redirect target this cycle
- fetch_discard  out  1  drop the current i_data_ok response
- stall_cycles  out  CNT_W  saturating count of cycles with stall_f = 1

Behaviour:
- Reset (reset = 0 at a clk edge):
  - FSM goes to F_IDLE; stall_cycles goes to 0.
  - All control outputs are 0 while reset is low.
  - Reset mid-fetch drops the outstanding request; no discard is pending afterwards (the bus is reset together with the core).
- Internal terms (combinational):
  - dstall = d_req_valid & ~d_data_ok
  - redir = ex_redirect & ~dstall
  - lu = ex_is_load & (ex_rd != 0) & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd))
  - istall = (state == F_WAIT | state == F_DISCARD) & ~i_data_ok, OR (state == F_IDLE & i_req_valid & ~i_data_ok)
- Output priority, highest first:
  1. dstall: stall_f/d/e/m = 1, flush_w = 1; redirect_ok = 0; lu and redirect are ignored.
  2. redir: flush_d = 1, flush_e = 1, redirect_ok = 1; stall_f = istall; lu is ignored.
  3. lu: stall_f = 1, stall_d = 1, flush_e = 1. One bubble only; the next cycle the load is in M, and forwarding is handled elsewhere.
  4. istall: stall_f = 1, flush_d = 1.
  5. Otherwise all outputs are 0.
- Fetch FSM states: F_IDLE, F_WAIT, F_DISCARD.
  - F_IDLE: i_req_valid & ~i_data_ok goes to F_WAIT, or to F_DISCARD if redir is also asserted. Request and response in the same cycle stays in F_IDLE; a wrong-path word is removed by flush_d.
  - F_WAIT: redir & ~i_data_ok goes to F_DISCARD. i_data_ok goes to F_IDLE; if redir is asserted in the same cycle, flush_d removes the word.
  - F_DISCARD: on i_data_ok, fetch_discard = 1 and stall_f = 1 for that cycle (the PC holds the redirect target and refetches next cycle), then go to F_IDLE. Further redir while in F_DISCARD stays in F_DISCARD.
- fetch_discard is asserted only in F_DISCARD with i_data_ok.
- stall_cycles:
  - Increments on every cycle with stall_f = 1.
  - Holds at all-ones and never wraps.
  - Registered; the value updates one cycle after the stall.

Decomposition:
- pipes package gets `fetch_state_t` (enum, 2 bits: F_IDLE/F_WAIT/F_DISCARD) and a `hazard_t` struct bundling the stall/flush outputs.
- One combinational sub-module `load_use_detect` computes lu. The FSM, priority logic and counter stay in hazard_ctrl.

Test Plan:
- Load-use: E = `ld x5`, D = `add x6,x5,x1` (id_use_rs1 = 1, rs1 = 5) -> one cycle of stall_f = stall_d = flush_e = 1. With ex_rd = 0, no stall.
- dbus wait: d_req_valid = 1 with d_data_ok low for 3 cycles -> stall_f/d/e/m and flush_w high for exactly 3 cycles. ex_redirect = 1 during that window gives redirect_ok = 0 until cycle 4.
- Redirect during fetch: i_req_valid at cycle 0, ex_redirect at cycle 1, i_data_ok at cycle 3 -> FSM goes F_WAIT then F_DISCARD; fetch_discard = 1 only at cycle 3; FSM is F_IDLE at cycle 4.
- Simultaneous lu and redir -> flush_d = flush_e = 1, stall_d = 0.
- Counter saturation: preload near max via a CNT_W = 4 build, run 20 stall cycles -> stall_cycles = 15.
- Reset asserted while in F_DISCARD -> next cycle state is F_IDLE, all outputs 0, a late i_data_ok gives fetch_discard = 0.
